// File: rtl/hack_uart_tx_pkg.sv
// Shared definitions for the Hack serial link: FSM encoding and 8N1 two-byte framing constants.
package hack_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  localparam int unsigned DataBits     = 8;
  localparam int unsigned BytesPerWord = 2;
  localparam logic        StartBit     = 1'b0;
  localparam logic        StopBit      = 1'b1;

endpackage

// File: rtl/hack_uart_tx_baud_tick.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and flags the last cycle of each bit.
module hack_uart_tx_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntLast);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hack_uart_tx.sv
// Sends a 16-bit Hack word as two 8N1 serial frames, low byte first; all outputs come from flops.
module hack_uart_tx
  import hack_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam logic [2:0] BitLast  = 3'(DataBits - 1);
  localparam logic       ByteLast = 1'(BytesPerWord - 1);

  state_e      state_q;
  logic [15:0] shreg_q;
  logic [2:0]  bit_idx_q;
  logic        byte_idx_q;
  logic        tx_q, ready_q, busy_q, done_q;
  logic        tick;

  // Counter is held at zero while idle, and every other state change happens on a wrap,
  // so each state is entered with a fresh count.
  hack_uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state_q == StIdle),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= 1'b0;
      tx_q       <= StopBit;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shreg_q    <= in;
            byte_idx_q <= 1'b0;
            tx_q       <= StartBit;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (tick) begin
            shreg_q <= shreg_q >> 1;
            if (bit_idx_q == BitLast) begin
              tx_q    <= StopBit;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (byte_idx_q == ByteLast) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              // High byte already sits in the low bits after eight shifts.
              byte_idx_q <= byte_idx_q + 1'b1;
              tx_q       <= StartBit;
              state_q    <= StStart;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
